parser_stream_ctrl: RTL and testbench

- Sequencer that sits in front of if_else_parser.
- Buffers an ASCII program written by a host, resets the parser, then streams the characters with timed char_valid pulses.
- Watches parsing_done/error_flag and returns a single registered result (p value, status code) to the host.
- Replaces hand-timed stimulus with a reusable, cycle-exact feeder.

---
 rtl/if_parser_pkg.sv | 21 ++
 rtl/parser_stream_ctrl_if.sv | 36 +++
 rtl/parser_stream_ctrl_char_fifo.sv | 51 +++++
 rtl/parser_stream_ctrl.sv | 175 +++++++++++++++++
 tb/tb_parser_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_parser_pkg.sv
// Shared constants and types for the parser stream controller.
// Result codes, FSM state encoding and character width.
package if_parser_pkg;

    localparam int ASCII_W = 7;

    localparam logic [1:0] RES_OK    = 2'd0;
    localparam logic [1:0] RES_PERR  = 2'd1;
    localparam logic [1:0] RES_TMO   = 2'd2;
    localparam logic [1:0] RES_EMPTY = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRST   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_GAP    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

endpackage

// File: rtl/parser_stream_ctrl_if.sv
// Host + parser-facing signal bundle of parser_stream_ctrl.
// slave is the controller's view, master is the environment's view.
interface parser_stream_ctrl_if;

    logic                               wr_en;
    logic [if_parser_pkg::ASCII_W-1:0]  wr_char;
    logic                               wr_full;
    logic [31:0]                        x_in;
    logic                               start;
    logic                               clear;
    logic                               busy;
    logic                               prs_rst;
    logic [31:0]                        prs_x;
    logic [if_parser_pkg::ASCII_W-1:0]  prs_char;
    logic                               prs_valid;
    logic [31:0]                        prs_p;
    logic                               prs_done;
    logic                               prs_err;
    logic                               res_valid;
    logic [31:0]                        res_p;
    logic [1:0]                         res_code;
    logic                               wr_ovf;

    modport slave (
        input  wr_en, wr_char, x_in, start, clear, prs_p, prs_done, prs_err,
        output wr_full, busy, prs_rst, prs_x, prs_char, prs_valid,
               res_valid, res_p, res_code, wr_ovf
    );

    modport master (
        output wr_en, wr_char, x_in, start, clear, prs_p, prs_done, prs_err,
        input  wr_full, busy, prs_rst, prs_x, prs_char, prs_valid,
               res_valid, res_p, res_code, wr_ovf
    );

endinterface

// File: rtl/parser_stream_ctrl_char_fifo.sv
// Circular character buffer with one extra pointer bit to tell full from empty.
// flush drops every stored entry and overrides a same-cycle push.
module char_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;

    // Pointer bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
    end

endmodule

// File: rtl/parser_stream_ctrl.sv
// Buffers a host-written program, resets the parser, streams it with timed
// char_valid pulses and reports one registered result per run.
module parser_stream_ctrl
    import if_parser_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int HOLD_CYC    = 2,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    parser_stream_ctrl_if.slave  bus
);

    localparam int CW = $clog2(HOLD_CYC + GAP_CYC + TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TMO_INIT  = CW'(TIMEOUT_CYC);

    state_t               state_r, state_n;
    logic [CW-1:0]        cnt_r, cnt_n;
    logic                 pop_s, flush_s, push_s;
    logic                 full_s, empty_s;
    logic [ASCII_W-1:0]   head_s;
    logic [1:0]           code_s;
    logic                 start_run_s;
    logic                 idle_s;

    logic                 busy_r, prs_rst_r, prs_valid_r, res_valid_r, wr_ovf_r;
    logic [ASCII_W-1:0]   prs_char_r;
    logic [31:0]          prs_x_r, res_p_r;
    logic [1:0]           res_code_r;

    assign idle_s = (state_r == ST_IDLE);
    assign push_s = bus.wr_en && idle_s;

    char_fifo #(.DEPTH(DEPTH), .W(ASCII_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (bus.wr_char),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Next-state, timer and buffer control.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        code_s      = RES_OK;
        start_run_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear) begin
                    flush_s = 1'b1;
                end else if (bus.start) begin
                    // A write landing with start counts as program content.
                    if (empty_s && !bus.wr_en) begin
                        state_n = ST_REPORT;
                        code_s  = RES_EMPTY;
                    end else begin
                        state_n     = ST_PRST;
                        start_run_s = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRST: begin
                state_n = ST_HOLD;
                cnt_n   = HOLD_LAST;
            end
            ST_HOLD, ST_GAP: begin
                if (bus.prs_err) begin
                    state_n = ST_REPORT;
                    flush_s = 1'b1;
                    code_s  = RES_PERR;
                end else if (bus.prs_done) begin
                    state_n = ST_REPORT;
                    flush_s = 1'b1;
                    code_s  = RES_OK;
                end else if (cnt_r != '0) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else if (state_r == ST_HOLD) begin
                    pop_s   = 1'b1;
                    state_n = ST_GAP;
                    cnt_n   = GAP_LAST;
                end else if (!empty_s) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LAST;
                end else begin
                    state_n = ST_WAIT;
                    cnt_n   = TMO_INIT;
                end
            end
            ST_WAIT: begin
                if (bus.prs_err) begin
                    state_n = ST_REPORT;
                    code_s  = RES_PERR;
                end else if (bus.prs_done) begin
                    state_n = ST_REPORT;
                    code_s  = RES_OK;
                end else if (cnt_r == CNT_ONE) begin
                    state_n = ST_REPORT;
                    code_s  = RES_TMO;
                end else begin
                    cnt_n = cnt_r - CNT_ONE;
                end
            end
            ST_REPORT: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, timer and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            prs_rst_r   <= 1'b1;
            prs_valid_r <= 1'b0;
            prs_char_r  <= '0;
            prs_x_r     <= 32'd0;
            res_valid_r <= 1'b0;
            res_p_r     <= 32'd0;
            res_code_r  <= RES_OK;
            wr_ovf_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            busy_r      <= (state_n == ST_PRST) || (state_n == ST_HOLD) ||
                           (state_n == ST_GAP)  || (state_n == ST_WAIT);
            prs_rst_r   <= !((state_n == ST_HOLD) || (state_n == ST_GAP) || (state_n == ST_WAIT));
            prs_valid_r <= (state_n == ST_HOLD);
            if (state_n == ST_HOLD) prs_char_r <= head_s;
            if (start_run_s)        prs_x_r    <= bus.x_in;
            if (state_n == ST_REPORT) begin
                res_valid_r <= 1'b1;
                res_code_r  <= code_s;
                res_p_r     <= (code_s == RES_EMPTY) ? 32'd0 : bus.prs_p;
            end else if (idle_s && (bus.clear || bus.start)) begin
                res_valid_r <= 1'b0;
            end
            if (idle_s && (bus.clear || bus.start)) begin
                wr_ovf_r <= 1'b0;
            end else if (push_s && full_s) begin
                wr_ovf_r <= 1'b1;
            end
        end
    end

    assign bus.wr_full   = full_s;
    assign bus.busy      = busy_r;
    assign bus.prs_rst   = prs_rst_r;
    assign bus.prs_x     = prs_x_r;
    assign bus.prs_char  = prs_char_r;
    assign bus.prs_valid = prs_valid_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_p     = res_p_r;
    assign bus.res_code  = res_code_r;
    assign bus.wr_ovf    = wr_ovf_r;

endmodule

// File: tb/tb_parser_stream_ctrl.sv
// Self-checking bench for parser_stream_ctrl: a parser stub driven by simple
// trigger rules plus an arithmetic model of what each run must produce.
module tb_parser_stream_ctrl;
    import if_parser_pkg::*;

    localparam int DEPTH       = 32;
    localparam int HOLD_CYC    = 2;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int NONE        = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parser_stream_ctrl_if bus();

    parser_stream_ctrl #(
        .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [6:0] prog_q[$];
    logic [6:0] rx_q[$];
    int hold_q[$];
    int gap_q[$];
    int hi_run, low_run, last_fall_cyc, unstable;
    logic prev_valid;
    int done_at = NONE, done_dly = 1, err_at = NONE, err_dly = 1;

    always @(posedge clk) cyc++;

    // Parser stub and stream monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst || bus.prs_rst) begin
            bus.prs_done = 1'b0;
            bus.prs_err  = 1'b0;
            hi_run       = 0;
            low_run      = 0;
            prev_valid   = 1'b0;
        end else begin
            if (bus.prs_valid) begin
                if (!prev_valid) begin
                    if (rx_q.size() > 0) gap_q.push_back(low_run);
                    rx_q.push_back(bus.prs_char);
                    hi_run = 1;
                end else begin
                    hi_run++;
                    if (bus.prs_char !== rx_q[rx_q.size()-1]) unstable++;
                end
            end else begin
                if (prev_valid) begin
                    hold_q.push_back(hi_run);
                    low_run       = 1;
                    last_fall_cyc = cyc;
                end else begin
                    low_run++;
                end
                if (rx_q.size() >= err_at && low_run >= err_dly)   bus.prs_err  = 1'b1;
                if (rx_q.size() >= done_at && low_run >= done_dly) bus.prs_done = 1'b1;
            end
            prev_valid = bus.prs_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int d_at, input int d_dly, input int e_at, input int e_dly);
        done_at = d_at; done_dly = d_dly; err_at = e_at; err_dly = e_dly;
    endtask

    task automatic set_prog(input string s);
        prog_q.delete();
        for (int i = 0; i < s.len(); i++) prog_q.push_back(7'(s[i]));
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog_q.size(); i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_char = prog_q[i];
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
    endtask

    // Start a run, follow it to its result and compare against the model.
    task automatic run_check(input string tag, input int exp_n, input logic [1:0] exp_code,
                             input logic [31:0] exp_p, input int exp_lat);
        logic [31:0] x;
        int bad, k;
        x = bus.x_in;
        rx_q.delete(); hold_q.delete(); gap_q.delete(); unstable = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check({tag, ".prst_busy"}, bus.busy, 1);
        check({tag, ".prst_rst"}, bus.prs_rst, 1);
        check({tag, ".res_cleared"}, bus.res_valid, 0);
        check({tag, ".ovf_cleared"}, bus.wr_ovf, 0);
        @(negedge clk);
        check({tag, ".first_valid"}, bus.prs_valid, 1);
        check({tag, ".prs_x"}, bus.prs_x, x);
        check({tag, ".prs_rst_low"}, bus.prs_rst, 0);
        k = 0;
        while (!bus.res_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".res_valid"}, bus.res_valid, 1);
        check({tag, ".res_code"}, bus.res_code, exp_code);
        check({tag, ".res_p"}, bus.res_p, exp_p);
        check({tag, ".busy_low"}, bus.busy, 0);
        check({tag, ".latency"}, cyc - last_fall_cyc, exp_lat);
        check({tag, ".n_chars"}, rx_q.size(), exp_n);
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < prog_q.size(); i++)
            if (rx_q[i] !== prog_q[i]) bad++;
        foreach (hold_q[i]) if (hold_q[i] != HOLD_CYC) bad++;
        foreach (gap_q[i])  if (gap_q[i] != GAP_CYC) bad++;
        check({tag, ".stream_shape"}, bad + unstable, 0);
        @(negedge clk);
        check({tag, ".res_sticky"}, bus.res_valid, 1);
    endtask

    task automatic empty_check(input string tag);
        rx_q.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".res_valid"}, bus.res_valid, 1);
        check({tag, ".code"}, bus.res_code, RES_EMPTY);
        check({tag, ".busy"}, bus.busy, 0);
        repeat (3) @(negedge clk);
        check({tag, ".no_valid"}, rx_q.size(), 0);
    endtask

    initial begin
        int len, sc, e_n, e_lat;
        logic [1:0] e_code;
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_char = '0; bus.x_in = 32'd0;
        bus.start = 1'b0; bus.clear = 1'b0; bus.prs_p = 32'd0;
        repeat (3) @(negedge clk);
        check("rst.busy", bus.busy, 0);
        check("rst.prs_rst", bus.prs_rst, 1);
        check("rst.prs_valid", bus.prs_valid, 0);
        check("rst.prs_char", bus.prs_char, 0);
        check("rst.prs_x", bus.prs_x, 0);
        check("rst.res_valid", bus.res_valid, 0);
        check("rst.res_p", bus.res_p, 0);
        check("rst.res_code", bus.res_code, 0);
        check("rst.wr_ovf", bus.wr_ovf, 0);
        check("rst.wr_full", bus.wr_full, 0);
        rst = 1'b1;
        @(negedge clk);

        // Full program, both branches of the if/else.
        for (int t = 0; t < 2; t++) begin
            set_prog("ifx==10p<=20elsep<=30");
            bus.x_in  = (t == 0) ? 32'd15 : 32'd10;
            bus.prs_p = (bus.x_in == 32'd10) ? 32'd20 : 32'd30;
            cfg(21, GAP_CYC + 3, NONE, 1);
            load_prog();
            run_check(t == 0 ? "prog_x15" : "prog_x10", 21, RES_OK,
                      t == 0 ? 32'd30 : 32'd20, GAP_CYC + 3);
        end

        empty_check("empty");

        // Parser error after the third character.
        set_prog("ifq");
        bus.prs_p = 32'h0000_0bad;
        cfg(NONE, 1, 3, 1);
        load_prog();
        run_check("perr", 3, RES_PERR, 32'h0000_0bad, 1);
        empty_check("perr_flushed");

        // No parsing_done at all.
        set_prog("ifx");
        bus.prs_p = 32'h1234_5678;
        cfg(NONE, 1, NONE, 1);
        load_prog();
        run_check("timeout", 3, RES_TMO, 32'h1234_5678, GAP_CYC + TIMEOUT_CYC);

        // Overflow: 33 writes into 32 entries.
        prog_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) prog_q.push_back(7'($urandom_range(32, 126)));
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_char = prog_q[i];
            @(negedge clk);
            if (i == DEPTH - 2) check("ovf.not_full_31", bus.wr_full, 0);
            if (i == DEPTH - 1) begin
                check("ovf.full_32", bus.wr_full, 1);
                check("ovf.no_ovf_yet", bus.wr_ovf, 0);
            end
        end
        bus.wr_en = 1'b0;
        check("ovf.sticky", bus.wr_ovf, 1);
        bus.prs_p = 32'h0000_0032;
        cfg(DEPTH, 1, NONE, 1);
        run_check("ovf_run", DEPTH, RES_OK, 32'h0000_0032, 1);

        // clear beats start; result dropped and buffer flushed.
        set_prog("abc");
        load_prog();
        bus.clear = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.start = 1'b0;
        check("clear.no_run", bus.busy, 0);
        check("clear.res_dropped", bus.res_valid, 0);
        empty_check("clear_flushed");

        // start together with a write: the write joins the run.
        set_prog("xyz");
        prog_q.pop_back();
        load_prog();
        prog_q.push_back(7'h7a);
        bus.wr_en = 1'b1; bus.wr_char = 7'h7a;
        bus.prs_p = 32'd7;
        cfg(3, 2, NONE, 1);
        run_check("start_wr", 3, RES_OK, 32'd7, 2);

        // Randomized runs against the trigger model.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(2, 20);
            sc  = r % 4;
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(7'($urandom_range(32, 126)));
            bus.x_in  = $urandom;
            bus.prs_p = $urandom;
            case (sc)
                0: begin cfg(len, $urandom_range(1, GAP_CYC + TIMEOUT_CYC), NONE, 1);
                         e_n = len; e_code = RES_OK; e_lat = done_dly; end
                1: begin cfg($urandom_range(1, len - 1), $urandom_range(1, GAP_CYC), NONE, 1);
                         e_n = done_at; e_code = RES_OK; e_lat = done_dly; end
                2: begin err_at = $urandom_range(1, len); err_dly = $urandom_range(1, GAP_CYC);
                         done_at = err_at; done_dly = err_dly;
                         e_n = err_at; e_code = RES_PERR; e_lat = err_dly; end
                default: begin cfg(NONE, 1, NONE, 1);
                         e_n = len; e_code = RES_TMO; e_lat = GAP_CYC + TIMEOUT_CYC; end
            endcase
            load_prog();
            run_check($sformatf("rnd%0d", r), e_n, e_code, bus.prs_p, e_lat);
        end

        // Asynchronous reset in the middle of a HOLD phase.
        set_prog("ifx==1");
        cfg(NONE, 1, NONE, 1);
        load_prog();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 50 && !bus.prs_valid; k++) @(negedge clk);
        check("midrst.in_hold", bus.prs_valid, 1);
        rst = 1'b0;
        #1;
        check("midrst.valid", bus.prs_valid, 0);
        check("midrst.prs_rst", bus.prs_rst, 1);
        check("midrst.busy", bus.busy, 0);
        check("midrst.full", bus.wr_full, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        empty_check("midrst_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
